// File: rtl/tomasula_types.sv
// Shared types for the Tomasulo core: reorder-buffer entry layout and widths.
package tomasula_types;

  localparam int ROB_XLEN = 32;
  localparam int RD_W     = 5;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            mispredict;
    logic            is_store;
    logic            is_br;
    logic [RD_W-1:0] rd;
    logic [ROB_XLEN-1:0] data;
  } rob_entry_t;

  function automatic rob_entry_t rob_entry_alloc(input logic [RD_W-1:0] rd,
                                                 input logic is_store,
                                                 input logic is_br);
    rob_entry_t e;
    e            = '0;
    e.busy       = 1'b1;
    e.rd         = rd;
    e.is_store   = is_store;
    e.is_br      = is_br;
    return e;
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrap-around pointer for a power-of-two ring; clear has priority over increment.
module rob_ptr #(
  parameter  int DEPTH = 8,
  localparam int W     = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate/commit, multi-port CDB completion,
// and a full flush when a mispredicted branch retires.
module rob_param
  import tomasula_types::*;
#(
  parameter  int DEPTH   = 8,
  parameter  int NUM_CDB = 4,
  parameter  int XLEN    = ROB_XLEN,
  localparam int TAG_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     alloc_valid,
  input  logic [4:0]               alloc_rd,
  input  logic                     alloc_is_store,
  input  logic                     alloc_is_br,
  output logic                     alloc_ready,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
  input  logic [NUM_CDB-1:0]       cdb_mispredict,
  output logic                     commit_valid,
  input  logic                     commit_ready,
  output logic [TAG_W-1:0]         commit_tag,
  output logic [4:0]               commit_rd,
  output logic [XLEN-1:0]          commit_data,
  output logic                     commit_is_store,
  output logic                     flush,
  output logic [DEPTH-1:0]         entry_done,
  output logic [TAG_W-1:0]         head_ptr,
  output logic [TAG_W-1:0]         tail_ptr,
  output logic [TAG_W:0]           count,
  output logic                     full,
  output logic                     empty
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  rob_entry_t        ent [DEPTH];
  logic [TAG_W-1:0]  cdb_tag_a  [NUM_CDB];
  logic [XLEN-1:0]   cdb_data_a [NUM_CDB];
  logic              alloc_fire;
  logic              commit_fire;
  logic              flush_now;

  always_comb begin
    for (int p = 0; p < NUM_CDB; p++) begin
      cdb_tag_a[p]  = cdb_tag[p*TAG_W +: TAG_W];
      cdb_data_a[p] = cdb_data[p*XLEN +: XLEN];
    end
  end

  // Both handshakes are valid/ready: a transfer happens on a clock edge where
  // valid and ready are both high; neither ready depends on its own valid.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign commit_valid = ent[head_ptr].busy & ent[head_ptr].done;
  assign commit_fire  = commit_valid & commit_ready;
  assign flush_now    = commit_fire & ent[head_ptr].mispredict;
  assign alloc_ready  = !full & !flush_now;
  assign alloc_fire   = alloc_valid & alloc_ready;
  assign alloc_tag    = tail_ptr;

  assign commit_tag      = head_ptr;
  assign commit_rd       = ent[head_ptr].rd;
  assign commit_data     = XLEN'(ent[head_ptr].data);
  assign commit_is_store = ent[head_ptr].is_store;

  always_comb begin
    entry_done = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_done[i] = ent[i].busy & ent[i].done;
    end
  end

  rob_ptr #(.DEPTH(DEPTH)) u_head (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (commit_fire),
    .clr     (flush_now),
    .ptr     (head_ptr)
  );

  rob_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (alloc_fire),
    .clr     (flush_now),
    .ptr     (tail_ptr)
  );

  // CDB ports are applied highest index first so port 0 lands last and wins a tag clash.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush_now) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int p = NUM_CDB-1; p >= 0; p--) begin
        if (cdb_valid[p] && ent[cdb_tag_a[p]].busy) begin
          ent[cdb_tag_a[p]].done       <= 1'b1;
          ent[cdb_tag_a[p]].data       <= ROB_XLEN'(cdb_data_a[p]);
          ent[cdb_tag_a[p]].mispredict <= cdb_mispredict[p] & ent[cdb_tag_a[p]].is_br;
        end
      end
      if (alloc_fire) begin
        ent[tail_ptr] <= rob_entry_alloc(alloc_rd, alloc_is_store, alloc_is_br);
      end
      if (commit_fire) begin
        ent[head_ptr].busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      flush <= 1'b0;
    end else begin
      flush <= flush_now;
      if (flush_now) begin
        count <= '0;
      end else begin
        count <= count + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, commit_fire};
      end
    end
  end

endmodule
